connectn_game: RTL and testbench

Parametrised Connect-N game for the arcade: COLS×ROWS board, WIN_LEN-in-a-row, gravity drop animation, multi-cycle win check around the last piece, draw detection, and an optional wrap-around cursor. It plugs into the arcade top level on the same slot interface as the other games: debounced button pulses in, 16 LEDs, an 8×8 grid, `check_ok`, and `score` out.

---
 rtl/connectn_game.sv | 210 +++++++++++++++++++++
 tb/tb_connectn_game.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connectn_game.sv
// Connect-N arcade game: cursor selection, gravity drop animation, a 4-cycle
// line check around the last piece, and draw detection.
module connectn_game #(
    parameter int COLS       = 7,
    parameter int ROWS       = 6,
    parameter int WIN_LEN    = 4,
    parameter int DROP_DELAY = 2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn_pulse,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [63:0] grid,
    output logic        check_ok,
    output logic [7:0]  score
);

    localparam int MIN_DIM = (COLS < ROWS) ? COLS : ROWS;
    localparam int CNT_W   = (DROP_DELAY > 1) ? $clog2(DROP_DELAY) : 1;
    localparam logic [2:0]       CUR_HOME = 3'(COLS / 2);
    localparam logic [2:0]       CUR_MAX  = 3'(COLS - 1);
    localparam logic [2:0]       ROW_TOP  = 3'(ROWS - 1);
    localparam logic [5:0]       CELLS    = 6'(COLS * ROWS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_DELAY - 1);

    if (COLS < 4 || COLS > 8 || ROWS < 4 || ROWS > 7 ||
        WIN_LEN < 3 || WIN_LEN > MIN_DIM || DROP_DELAY < 1) begin : g_param_check
        $error("connectn_game: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, PLAY, DROP, CHECK, OVER} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       board_reg [ROWS][COLS];
    logic [1:0]       player_reg, winner_reg;
    logic [2:0]       cursor_reg, target_reg, anim_row_reg;
    logic [5:0]       count_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       dir_reg;
    logic             win_reg, draw_reg, invalid_reg;

    logic btn_sel, move_left, move_right;
    logic col_full;
    logic [2:0] low_row;
    logic [4:0] line_len;
    logic line_win;
    logic unused_inputs;

    // Select has priority; a move only counts when it is the sole button pressed.
    assign btn_sel       = btn_pulse[4];
    assign move_left     = btn_pulse[2] & ~btn_pulse[3] & ~btn_pulse[4];
    assign move_right    = btn_pulse[3] & ~btn_pulse[2] & ~btn_pulse[4];
    assign unused_inputs = ^{btn_pulse[1:0], sw[15:1]};

    // Run of player-coloured cells leaving the placed cell in direction (dr,dc).
    function automatic logic [4:0] count_run(input int dr, input int dc);
        logic [4:0] n;
        logic       go;
        int         r, c;
        n  = '0;
        go = 1'b1;
        for (int k = 1; k < 8; k++) begin
            r = int'(target_reg) + k * dr;
            c = int'(cursor_reg) + k * dc;
            if (go && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                board_reg[3'(r)][3'(c)] == player_reg)
                n = n + 5'd1;
            else
                go = 1'b0;
        end
        return n;
    endfunction

    // Column under the cursor: lowest empty row and whether it is full.
    always_comb begin
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (board_reg[3'(r)][cursor_reg] == 2'b00)
                low_row = 3'(r);
        end
        col_full = (board_reg[ROWS-1][cursor_reg] != 2'b00);
    end

    // Line length through the placed cell for the direction checked this cycle.
    always_comb begin
        line_len = 5'd1;
        case (dir_reg)
            2'd0:    line_len = 5'd1 + count_run(0, 1) + count_run(0, -1);
            2'd1:    line_len = 5'd1 + count_run(1, 0) + count_run(-1, 0);
            2'd2:    line_len = 5'd1 + count_run(1, 1) + count_run(-1, -1);
            default: line_len = 5'd1 + count_run(1, -1) + count_run(-1, 1);
        endcase
        line_win = (line_len >= 5'(WIN_LEN));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (btn_sel) state_next = PLAY;
            PLAY:  if (btn_sel && !col_full) state_next = DROP;
            DROP:  if (cnt_reg == CNT_LAST && anim_row_reg == target_reg) state_next = CHECK;
            CHECK: if (dir_reg == 2'd3)
                       state_next = (win_reg || line_win || count_reg == CELLS) ? OVER : PLAY;
            OVER:  if (btn_sel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Game datapath: board, cursor, animation counter, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board_reg[r][c] <= 2'b00;
            player_reg   <= 2'b01;
            winner_reg   <= 2'b00;
            cursor_reg   <= CUR_HOME;
            target_reg   <= '0;
            anim_row_reg <= '0;
            count_reg    <= '0;
            cnt_reg      <= '0;
            dir_reg      <= '0;
            win_reg      <= 1'b0;
            draw_reg     <= 1'b0;
            invalid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (btn_sel) begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            board_reg[r][c] <= 2'b00;
                    player_reg  <= 2'b01;
                    winner_reg  <= 2'b00;
                    count_reg   <= '0;
                    win_reg     <= 1'b0;
                    draw_reg    <= 1'b0;
                    invalid_reg <= 1'b0;
                    cursor_reg  <= CUR_HOME;
                end
                PLAY: begin
                    if (btn_sel) begin
                        if (col_full) begin
                            invalid_reg <= 1'b1;
                        end else begin
                            target_reg   <= low_row;
                            anim_row_reg <= ROW_TOP;
                            cnt_reg      <= '0;
                            invalid_reg  <= 1'b0;
                        end
                    end else if (move_left) begin
                        invalid_reg <= 1'b0;
                        if (cursor_reg != 3'd0) cursor_reg <= cursor_reg - 3'd1;
                        else if (sw[0])         cursor_reg <= CUR_MAX;
                    end else if (move_right) begin
                        invalid_reg <= 1'b0;
                        if (cursor_reg != CUR_MAX) cursor_reg <= cursor_reg + 3'd1;
                        else if (sw[0])            cursor_reg <= 3'd0;
                    end
                end
                DROP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (anim_row_reg == target_reg) begin
                            board_reg[target_reg][cursor_reg] <= player_reg;
                            count_reg <= count_reg + 6'd1;
                            dir_reg   <= '0;
                        end else begin
                            anim_row_reg <= anim_row_reg - 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CHECK: begin
                    dir_reg <= dir_reg + 2'd1;
                    if (line_win) win_reg <= 1'b1;
                    if (dir_reg == 2'd3) begin
                        if (win_reg || line_win)  winner_reg <= player_reg;
                        else if (count_reg == CELLS) draw_reg <= 1'b1;
                        else                         player_reg <= ~player_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display: board rows flipped so row 0 sits at the bottom, plus overlays.
    always_comb begin
        grid = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                grid[6'((7 - r) * 8 + c)] = |board_reg[3'(r)][3'(c)];
        if (state_reg == DROP) grid[{3'd7 - anim_row_reg, cursor_reg}] = 1'b1;
        if (state_reg == PLAY) grid[{3'd0, cursor_reg}] = 1'b1;
    end

    assign led      = {winner_reg, count_reg, cursor_reg, draw_reg, invalid_reg, win_reg, player_reg};
    assign check_ok = win_reg;
    assign score    = {2'b00, count_reg};

endmodule

// File: tb/tb_connectn_game.sv
module tb_connectn_game;

    localparam int N = 4;
    localparam int P_COLS [N] = '{7, 7, 4, 4};
    localparam int P_ROWS [N] = '{6, 6, 4, 4};
    localparam int P_WIN  [N] = '{4, 4, 3, 4};
    localparam int P_DLY  [N] = '{1, 3, 1, 1};
    localparam logic [15:0] RST_LED [N] = '{16'h0061, 16'h0061, 16'h0041, 16'h0041};

    localparam int K_LED = 0, K_GRID = 1, K_SCORE = 2, K_OK = 3;
    localparam logic [4:0] B_L = 5'b00100, B_R = 5'b01000, B_S = 5'b10000;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_v   [N];
    logic [4:0]  btn_v   [N];
    logic [15:0] sw;
    logic [15:0] led_v   [N];
    logic [63:0] grid_v  [N];
    logic        ok_v    [N];
    logic [7:0]  score_v [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        connectn_game #(
            .COLS(P_COLS[gi]), .ROWS(P_ROWS[gi]),
            .WIN_LEN(P_WIN[gi]), .DROP_DELAY(P_DLY[gi])
        ) dut (
            .clk(clk), .rst(rst_v[gi]), .btn_pulse(btn_v[gi]), .sw(sw),
            .led(led_v[gi]), .grid(grid_v[gi]), .check_ok(ok_v[gi]), .score(score_v[gi])
        );
    end

    typedef struct {
        int          dut;
        string       name;
        int          kind;
        logic [63:0] exp;
        logic [63:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int cur [N];
    int cnt [N];
    int ht  [N][8];

    task automatic expect_out(input int d, input string name, input int kind,
                              input logic [63:0] exp, input logic [63:0] mask);
        exp_t e;
        e.dut = d; e.name = name; e.kind = kind; e.exp = exp; e.mask = mask;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() != 0) begin
                exp_t        e;
                logic [63:0] act;
                e = sb.pop_front();
                case (e.kind)
                    K_LED:   act = 64'(led_v[e.dut]);
                    K_GRID:  act = grid_v[e.dut];
                    K_SCORE: act = 64'(score_v[e.dut]);
                    default: act = 64'(ok_v[e.dut]);
                endcase
                checks++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %h required %h", e.name, e.dut,
                             act & e.mask, e.exp & e.mask);
                end else begin
                    $display("ok   %s dut%0d = %h", e.name, e.dut, act & e.mask);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d, input logic [4:0] b);
        btn_v[d] = b;
        tick();
        btn_v[d] = '0;
    endtask

    task automatic reset_model(input int d);
        cur[d] = P_COLS[d] / 2;
        cnt[d] = 0;
        for (int c = 0; c < 8; c++) ht[d][c] = 0;
    endtask

    task automatic new_game(input int d);
        press(d, B_S);
        reset_model(d);
    endtask

    task automatic move_to(input int d, input int col);
        while (cur[d] < col) begin press(d, B_R); cur[d]++; end
        while (cur[d] > col) begin press(d, B_L); cur[d]--; end
    endtask

    task automatic drop(input int d, input int col, input int win_at);
        int t;
        move_to(d, col);
        t = ht[d][col];
        press(d, B_S);
        repeat (P_DLY[d] * (P_ROWS[d] - t)) tick();
        ht[d][col]++;
        cnt[d]++;
        expect_out(d, "check_entry_win", K_LED, 64'h0, 64'h4);
        expect_out(d, "score_after_drop", K_SCORE, 64'(cnt[d]), ALL);
        for (int j = 0; j < 4; j++) begin
            tick();
            expect_out(d, $sformatf("check%0d_win", j), K_LED,
                       (j >= win_at) ? 64'h4 : 64'h0, 64'h4);
            if (j < 3) expect_out(d, $sformatf("check%0d_winner", j), K_LED, 64'h0, 64'hC000);
        end
    endtask

    task automatic expect_reset(input int d);
        expect_out(d, "rst_led", K_LED, 64'(RST_LED[d]), ALL);
        expect_out(d, "rst_grid", K_GRID, 64'h0, ALL);
        expect_out(d, "rst_score", K_SCORE, 64'h0, ALL);
        expect_out(d, "rst_check_ok", K_OK, 64'h0, ALL);
    endtask

    initial begin
        sw = '0;
        for (int d = 0; d < N; d++) begin
            rst_v[d] = 1'b1;
            btn_v[d] = '0;
            reset_model(d);
        end
        tick();
        tick();
        for (int d = 0; d < N; d++) expect_reset(d);
        for (int d = 0; d < N; d++) rst_v[d] = 1'b0;
        tick();

        new_game(0);
        expect_out(0, "start_led", K_LED, 64'h0061, ALL);
        expect_out(0, "start_grid", K_GRID, 64'h8, ALL);
        drop(0, 0, 9); drop(0, 0, 9); drop(0, 1, 9); drop(0, 1, 9);
        drop(0, 2, 9); drop(0, 2, 9); drop(0, 3, 0);
        expect_out(0, "hwin_led", K_LED, 64'h4765, ALL);
        expect_out(0, "hwin_ok", K_OK, 64'h1, ALL);
        expect_out(0, "hwin_score", K_SCORE, 64'd7, ALL);
        expect_out(0, "hwin_grid", K_GRID, 64'h0F07_0000_0000_0000, ALL);
        press(0, B_L);
        expect_out(0, "over_ignores_left", K_LED, 64'h4765, ALL);

        press(0, B_S);
        expect_out(0, "idle_keeps_grid", K_GRID, 64'h0F07_0000_0000_0000, ALL);
        new_game(0);
        repeat (5) press(0, B_L);
        cur[0] = 0;
        expect_out(0, "cursor_saturate", K_LED, 64'h0, 64'hE0);
        sw = 16'h0001;
        press(0, B_L);
        cur[0] = 6;
        expect_out(0, "cursor_wrap_left", K_LED, 64'hC0, 64'hE0);
        press(0, B_L | B_R);
        expect_out(0, "cursor_both", K_LED, 64'hC0, 64'hE0);
        press(0, B_R);
        expect_out(0, "cursor_wrap_right", K_LED, 64'h00, 64'hE0);
        press(0, B_L);
        expect_out(0, "cursor_wrap_back", K_LED, 64'hC0, 64'hE0);
        sw = '0;

        drop(0, 6, 9);
        expect_out(0, "after_move1_led", K_LED, 64'h01C2, ALL);
        press(0, B_S);
        tick();
        expect_out(0, "drop_grid", K_GRID, 64'h4000_0000_4000_0000, ALL);
        rst_v[0] = 1'b1;
        tick();
        expect_reset(0);
        rst_v[0] = 1'b0;
        reset_model(0);

        new_game(1);
        move_to(1, 2);
        press(1, B_S);
        for (int i = 0; i < 18; i++) begin
            expect_out(1, $sformatf("anim_%0d", i), K_GRID, 64'h1 << ((2 + i / 3) * 8 + 2), ALL);
            tick();
        end
        expect_out(1, "drop_end_grid", K_GRID, 64'h1 << 58, ALL);
        expect_out(1, "drop_end_score", K_SCORE, 64'd1, ALL);
        ht[1][2] = 1;
        cnt[1] = 1;
        repeat (4) tick();
        expect_out(1, "after_check_led", K_LED, 64'h0142, ALL);
        drop(1, 3, 9); drop(1, 2, 9); drop(1, 3, 9); drop(1, 2, 9);
        drop(1, 3, 9); drop(1, 2, 1);
        expect_out(1, "vwin_led", K_LED, 64'h4745, ALL);
        expect_out(1, "vwin_ok", K_OK, 64'h1, ALL);

        new_game(2);
        drop(2, 0, 9); drop(2, 1, 9); drop(2, 1, 9); drop(2, 2, 9);
        drop(2, 3, 9); drop(2, 2, 9); drop(2, 2, 2);
        expect_out(2, "dwin_led", K_LED, 64'h4745, ALL);
        expect_out(2, "dwin_score", K_SCORE, 64'd7, ALL);

        new_game(3);
        drop(3, 0, 9); drop(3, 0, 9); drop(3, 0, 9); drop(3, 0, 9);
        press(3, B_S);
        expect_out(3, "full_led", K_LED, 64'h0409, ALL);
        expect_out(3, "full_grid", K_GRID, 64'h0101_0101_0000_0001, ALL);
        expect_out(3, "full_score", K_SCORE, 64'd4, ALL);
        repeat (3) tick();
        expect_out(3, "full_stays_play", K_GRID, 64'h0101_0101_0000_0001, ALL);
        press(3, B_R);
        cur[3] = 1;
        expect_out(3, "invalid_cleared", K_LED, 64'h0421, ALL);
        rst_v[3] = 1'b1;
        tick();
        expect_reset(3);
        rst_v[3] = 1'b0;
        reset_model(3);

        new_game(3);
        drop(3, 0, 9); drop(3, 1, 9); drop(3, 2, 9); drop(3, 3, 9);
        drop(3, 0, 9); drop(3, 1, 9); drop(3, 2, 9); drop(3, 3, 9);
        drop(3, 1, 9); drop(3, 0, 9); drop(3, 3, 9); drop(3, 2, 9);
        drop(3, 1, 9); drop(3, 0, 9); drop(3, 3, 9); drop(3, 2, 9);
        expect_out(3, "draw_led", K_LED, 64'h1052, ALL);
        expect_out(3, "draw_score", K_SCORE, 64'd16, ALL);
        expect_out(3, "draw_ok", K_OK, 64'h0, ALL);
        expect_out(3, "draw_grid", K_GRID, 64'h0F0F_0F0F_0000_0000, ALL);
        press(3, B_S);
        expect_out(3, "idle_board_shown", K_GRID, 64'h0F0F_0F0F_0000_0000, ALL);
        expect_out(3, "idle_led_held", K_LED, 64'h1052, ALL);
        new_game(3);
        expect_out(3, "restart_grid", K_GRID, 64'h4, ALL);
        expect_out(3, "restart_led", K_LED, 64'h0041, ALL);
        expect_out(3, "restart_score", K_SCORE, 64'h0, ALL);

        tick();
        tick();

        checks++;
        if (led_v[3] !== 16'h0041) begin
            errors++;
            $display("FAIL final_led dut3: got %h required 0041", led_v[3]);
        end else begin
            $display("ok   final_led dut3 = %h", led_v[3]);
        end
        checks++;
        if (grid_v[3] !== 64'h4) begin
            errors++;
            $display("FAIL final_grid dut3: got %h required 4", grid_v[3]);
        end else begin
            $display("ok   final_grid dut3 = %h", grid_v[3]);
        end
        checks++;
        if (score_v[3] !== 8'h00) begin
            errors++;
            $display("FAIL final_score dut3: got %h required 00", score_v[3]);
        end else begin
            $display("ok   final_score dut3 = %h", score_v[3]);
        end
        checks++;
        if (ok_v[3] !== 1'b0) begin
            errors++;
            $display("FAIL final_check_ok dut3: got %b required 0", ok_v[3]);
        end else begin
            $display("ok   final_check_ok dut3 = %b", ok_v[3]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
